// File: rtl/tff_toggle_ctrl.sv
// Command-driven pulse sequencer for one T flip-flop, with a shadow
// copy of the expected q and a sticky, saturating mismatch checker.
module tff_toggle_ctrl #(
    parameter int CW = 8,
    parameter int GW = 4,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_count,
    input  logic [GW-1:0] cmd_gap,
    input  logic          abort,
    output logic          t_out,
    input  logic          q_in,
    input  logic          chk_en,
    input  logic          err_clr,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          q_exp,
    output logic          err,
    output logic [EW-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gcnt_q;
    logic [GW-1:0] gcnt_d;
    logic          aborted_q;
    logic          q_exp_q;
    logic          err_q;
    logic [EW-1:0] err_cnt_q;
    logic [EW-1:0] err_cnt_d;
    logic          mismatch;

    // Counters stop at zero instead of wrapping.
    assign cnt_d  = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    assign gcnt_d = (gcnt_q == '0) ? gcnt_q : gcnt_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt_q   <= cmd_count;
                        gap_q   <= cmd_gap;
                        state_q <= (cmd_count == '0) ? DONE : PULSE;
                    end
                end
                PULSE: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0 || abort) begin
                        state_q   <= DONE;
                        aborted_q <= (cnt_d != '0);
                    end else if (gap_q == '0) begin
                        state_q <= PULSE;
                    end else begin
                        state_q <= GAP;
                        gcnt_q  <= gap_q;
                    end
                end
                GAP: begin
                    gcnt_q <= gcnt_d;
                    if (abort) begin
                        state_q   <= DONE;
                        aborted_q <= 1'b1;
                    end else if (gcnt_q == GW'(1)) begin
                        state_q <= PULSE;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    aborted_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign t_out     = (state_q == PULSE);
    assign busy      = (state_q == PULSE) || (state_q == GAP);
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;

    assign mismatch  = chk_en && (q_in != q_exp_q);
    assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    // A mismatch in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (t_out) begin
                q_exp_q <= ~q_exp_q;
            end
            if (mismatch) begin
                err_q     <= 1'b1;
                err_cnt_q <= err_clr ? EW'(1) : err_cnt_d;
            end else if (err_clr) begin
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end
        end
    end

    assign q_exp   = q_exp_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
